// File: rtl/nn_mem_req_arbiter_if.sv
// Core-side request/response bundle for two requesters plus the memory-side port.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface nn_mem_req_arbiter_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 32,
  parameter int CREG_ID_BITS = 3
);
  localparam int L = CREG_ID_BITS - 1;

  logic [1:0]                 rq_valid;
  logic [1:0][ADDR_WIDTH-1:0] rq_addr;
  logic [1:0][LINE_WIDTH-1:0] rq_data;
  logic [1:0]                 rq_rw;
  logic [1:0][L-1:0]          rq_id;
  logic [1:0]                 rq_ready;

  logic [1:0]                 rs_valid;
  logic [1:0][LINE_WIDTH-1:0] rs_data;
  logic [1:0][L-1:0]          rs_id;

  logic [ADDR_WIDTH-1:0]      m_addr;
  logic [LINE_WIDTH-1:0]      m_data;
  logic                       m_rw;
  logic                       m_valid;
  logic [CREG_ID_BITS-1:0]    m_id;
  logic [LINE_WIDTH-1:0]      m_rdata;
  logic [CREG_ID_BITS-1:0]    m_rid;
  logic                       m_rready;
  logic                       m_stall;

  modport slave (
    input  rq_valid, rq_addr, rq_data, rq_rw, rq_id,
    output rq_ready,
    output rs_valid, rs_data, rs_id,
    output m_addr, m_data, m_rw, m_valid, m_id,
    input  m_rdata, m_rid, m_rready, m_stall
  );

  modport master (
    output rq_valid, rq_addr, rq_data, rq_rw, rq_id,
    input  rq_ready,
    input  rs_valid, rs_data, rs_id,
    input  m_addr, m_data, m_rw, m_valid, m_id,
    output m_rdata, m_rid, m_rready, m_stall
  );
endinterface

// File: rtl/nn_mem_req_arbiter.sv
// Two-port round-robin arbiter feeding mem_ctrl_wrapper: one held output request,
// responses routed back by id MSB, per-port outstanding throttling.

// Per-port outstanding counter; room is high while another response-bearing request fits.
module nn_mem_req_arbiter_cnt #(
  parameter int MAX_OUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic room
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  logic [CW-1:0] cnt;

  assign room = (cnt < MAX_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != MAX_C) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Overflow/underflow means the requester or memory broke the id contract.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(dec && !inc && cnt == '0));
      assert (!(inc && !dec && cnt == MAX_C));
    end
  end
endmodule

module nn_mem_req_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 32,
  parameter int CREG_ID_BITS = 3,
  parameter int MAX_OUT      = 4,
  parameter int WRITE_ACK    = 1
) (
  input  logic               clk,
  input  logic               reset,
  nn_mem_req_arbiter_if.slave bus
);
  localparam int L = CREG_ID_BITS - 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LINE_WIDTH-1:0]   data;
    logic                    rw;
    logic [CREG_ID_BITS-1:0] id;
  } mreq_t;

  mreq_t      mreq_q, mreq_nxt;
  logic       m_valid_q;
  logic       rr;
  logic       load_en, sel, rsp_port;
  logic [1:0] room, elig, grant, inc, dec;

  logic [1:0]                 rs_valid_q;
  logic [1:0][LINE_WIDTH-1:0] rs_data_q;
  logic [1:0][L-1:0]          rs_id_q;

  assign rsp_port = bus.m_rid[CREG_ID_BITS-1];

  always_comb begin
    load_en = !m_valid_q || !bus.m_stall;
    elig    = bus.rq_valid & room;
    // Under contention the port that did not win last time goes first.
    grant   = (elig == 2'b11) ? (rr ? 2'b01 : 2'b10) : elig;
    sel     = grant[1];
    mreq_nxt.addr = bus.rq_addr[sel];
    mreq_nxt.data = bus.rq_data[sel];
    mreq_nxt.rw   = bus.rq_rw[sel];
    mreq_nxt.id   = {sel, bus.rq_id[sel]};
  end

  assign bus.rq_ready = {2{reset & load_en}} & grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mreq_q    <= '0;
      m_valid_q <= 1'b0;
      rr        <= 1'b0;
    end else if (load_en) begin
      if (|grant) begin
        mreq_q    <= mreq_nxt;
        m_valid_q <= 1'b1;
        rr        <= sel;
      end else begin
        m_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_valid_q <= '0;
      rs_data_q  <= '0;
      rs_id_q    <= '0;
    end else begin
      rs_valid_q <= '0;
      if (bus.m_rready) begin
        rs_valid_q[rsp_port] <= 1'b1;
        rs_data_q[rsp_port]  <= bus.m_rdata;
        rs_id_q[rsp_port]    <= bus.m_rid[L-1:0];
      end
    end
  end

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_port
      // Writes only occupy an id slot when memory acknowledges them.
      assign inc[p] = bus.rq_ready[p] & (!bus.rq_rw[p] | (WRITE_ACK != 0));
      assign dec[p] = bus.m_rready & (rsp_port == 1'(p));

      nn_mem_req_arbiter_cnt #(.MAX_OUT(MAX_OUT)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[p]),
        .dec   (dec[p]),
        .room  (room[p])
      );
    end
  endgenerate

  assign bus.m_addr   = mreq_q.addr;
  assign bus.m_data   = mreq_q.data;
  assign bus.m_rw     = mreq_q.rw;
  assign bus.m_id     = mreq_q.id;
  assign bus.m_valid  = m_valid_q;
  assign bus.rs_valid = rs_valid_q;
  assign bus.rs_data  = rs_data_q;
  assign bus.rs_id    = rs_id_q;
endmodule

// File: tb/tb_nn_mem_req_arbiter.sv
// Randomized bench for nn_mem_req_arbiter against a transaction-level model
// (outstanding counts, last winner, held request, memory pending-id list).
module tb_nn_mem_req_arbiter;
  localparam int AW = 32, LW = 32, IDB = 3, MAXO = 4, WA = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nn_mem_req_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CREG_ID_BITS(IDB)) bus ();

  nn_mem_req_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CREG_ID_BITS(IDB), .MAX_OUT(MAXO), .WRITE_ACK(WA)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0, n_err = 0;

  // reference model state
  int          cnt [2];
  int          last_win;
  bit          mv;
  logic [31:0] ma, md;
  bit          mrw;
  logic [2:0]  mid;
  bit          rsv [2];
  logic [31:0] rsd [2];
  logic [1:0]  rsi [2];
  logic [2:0]  pend [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    cnt[0] = 0; cnt[1] = 0; last_win = 0; mv = 0; ma = 0; md = 0; mrw = 0; mid = 0;
    for (int i = 0; i < 2; i++) begin rsv[i] = 0; rsd[i] = 0; rsi[i] = 0; end
    pend.delete();
  endtask

  // Inputs are already applied; compare, advance the model, move to the next negedge.
  task automatic step();
    int g;
    bit e0, e1, le;
    logic [1:0] exp_rdy;
    #1;
    e0 = bus.rq_valid[0] && (cnt[0] < MAXO);
    e1 = bus.rq_valid[1] && (cnt[1] < MAXO);
    if (e0 && e1)  g = (last_win == 0) ? 1 : 0;
    else if (e1)   g = 1;
    else if (e0)   g = 0;
    else           g = -1;
    le = !mv || !bus.m_stall;
    exp_rdy = 2'b00;
    if (reset && le && g >= 0) exp_rdy[g] = 1'b1;

    chk("rq_ready", bus.rq_ready, exp_rdy);
    chk("m_valid",  bus.m_valid, mv);
    chk("m_addr",   bus.m_addr, ma);
    chk("m_data",   bus.m_data, md);
    chk("m_rw",     bus.m_rw, mrw);
    chk("m_id",     bus.m_id, mid);
    chk("rs_valid", bus.rs_valid, {rsv[1], rsv[0]});
    chk("rs_data0", bus.rs_data[0], rsd[0]);
    chk("rs_data1", bus.rs_data[1], rsd[1]);
    chk("rs_id0",   bus.rs_id[0], rsi[0]);
    chk("rs_id1",   bus.rs_id[1], rsi[1]);

    if (!reset) begin
      model_clear();
    end else begin
      if (mv && !bus.m_stall && (!mrw || WA != 0)) pend.push_back(mid);
      rsv[0] = 0; rsv[1] = 0;
      if (bus.m_rready) begin
        int p = int'(bus.m_rid[2]);
        rsv[p] = 1; rsd[p] = bus.m_rdata; rsi[p] = bus.m_rid[1:0];
        cnt[p]--;
      end
      if (le) begin
        if (g >= 0) begin
          ma = bus.rq_addr[g]; md = bus.rq_data[g]; mrw = bus.rq_rw[g];
          mid = {g[0], bus.rq_id[g]};
          mv = 1; last_win = g;
          if (!bus.rq_rw[g] || WA != 0) cnt[g]++;
        end else begin
          mv = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic no_rsp();
    bus.m_rready = 0; bus.m_rid = 3'($urandom); bus.m_rdata = $urandom;
  endtask

  task automatic send_rsp(input int k);
    bus.m_rready = 1; bus.m_rid = pend[k]; bus.m_rdata = $urandom; pend.delete(k);
  endtask

  task automatic drive_rsp(input int prob);
    if (reset && pend.size() > 0 && $urandom_range(0, 99) < prob)
      send_rsp($urandom_range(0, pend.size() - 1));
    else
      no_rsp();
  endtask

  task automatic drive_req(input logic [1:0] v);
    bus.rq_valid = v;
    for (int p = 0; p < 2; p++) begin
      bus.rq_addr[p] = $urandom; bus.rq_data[p] = $urandom;
      bus.rq_rw[p] = ($urandom_range(0, 3) == 0); bus.rq_id[p] = 2'($urandom);
    end
  endtask

  function automatic int find_pend(input bit p);
    for (int i = 0; i < pend.size(); i++) if (pend[i][2] == p) return i;
    return -1;
  endfunction

  task automatic send_rsp_port(input bit p);
    int k = find_pend(p);
    chk("pend_found", (k >= 0), 1);
    if (k >= 0) send_rsp(k); else no_rsp();
  endtask

  task automatic drain();
    int n = 0;
    bus.rq_valid = 0; bus.m_stall = 0;
    while ((pend.size() > 0 || mv) && n < 64) begin drive_rsp(100); step(); n++; end
    no_rsp(); step();
    chk("drain_empty", pend.size(), 0);
  endtask

  initial begin
    logic [31:0] hold_addr;
    logic [2:0]  hold_id;
    bit prev_msb;
    model_clear();
    reset = 0; bus.m_stall = 0;
    drive_req(2'b00); no_rsp();
    @(negedge clk);

    // held reset with activity on the inputs
    for (int i = 0; i < 30; i++) begin drive_req(2'($urandom)); no_rsp(); step(); end
    reset = 1; drive_req(2'b00);
    for (int i = 0; i < 3; i++) step();
    chk("idle_mvalid", bus.m_valid, 0);

    // single port-1 read
    drive_req(2'b10); bus.rq_addr[1] = 32'h40; bus.rq_id[1] = 2'd2; bus.rq_rw[1] = 0;
    #1 chk("p1_ready", bus.rq_ready, 2'b10);
    step();
    bus.rq_valid = 0;
    #1 chk("p1_mid", bus.m_id, 3'b110); chk("p1_maddr", bus.m_addr, 32'h40);
    step();
    bus.m_rready = 1; bus.m_rid = 3'd6; bus.m_rdata = 32'h1234; void'(pend.pop_front());
    step();
    no_rsp();
    #1 chk("p1_rsvalid", bus.rs_valid, 2'b10); chk("p1_rsid", bus.rs_id[1], 2'd2);
    chk("p1_rsdata", bus.rs_data[1], 32'h1234);
    step();

    // continuous contention: winner alternates every cycle
    drive_req(2'b11); bus.rq_rw = 2'b00;
    step();
    prev_msb = bus.m_id[2];
    for (int i = 0; i < 5; i++) begin
      drive_req(2'b11); bus.rq_rw = 2'b00; step();
      chk("alternate", bus.m_id[2], !prev_msb);
      prev_msb = bus.m_id[2];
    end
    drain();

    // stall holds the output register and blocks accepts
    drive_req(2'b11); step();
    hold_addr = bus.m_addr; hold_id = bus.m_id;
    bus.m_stall = 1;
    for (int i = 0; i < 5; i++) begin
      drive_req(2'b11);
      #1 chk("stall_ready", bus.rq_ready, 2'b00);
      chk("stall_addr", bus.m_addr, hold_addr); chk("stall_id", bus.m_id, hold_id);
      step();
    end
    bus.m_stall = 0; drive_req(2'b11);
    #1 chk("unstall_acc", |bus.rq_ready, 1);
    step();
    drain();

    // port 0 fills its id space; port 1 still served
    for (int i = 0; i < 4; i++) begin drive_req(2'b01); bus.rq_rw = 2'b00; step(); end
    drive_req(2'b11);
    #1 chk("p0_full", bus.rq_ready, 2'b10);
    step();
    drive_req(2'b01); send_rsp_port(0);
    #1 chk("p0_still_full", bus.rq_ready, 2'b00);
    step();
    drive_req(2'b01); bus.rq_rw = 2'b00; no_rsp();
    #1 chk("p0_reopen", bus.rq_ready, 2'b01);
    step();
    // free one slot, then accept and respond on port 0 in the same cycle
    drive_req(2'b00); send_rsp_port(0); step();
    drive_req(2'b01); bus.rq_rw = 2'b00; send_rsp_port(0);
    #1 chk("p0_acc_rsp", bus.rq_ready, 2'b01);
    step();
    drive_req(2'b01); bus.rq_rw = 2'b00; no_rsp();
    #1 chk("p0_cnt_kept", bus.rq_ready, 2'b01);
    step();
    drive_req(2'b01);
    #1 chk("p0_full_again", bus.rq_ready, 2'b00);
    // one-cycle reset mid-traffic
    reset = 0; drive_req(2'b11);
    #1 chk("rst_ready", bus.rq_ready, 2'b00);
    step();
    reset = 1; drive_req(2'b01); bus.rq_rw = 2'b00;
    #1 chk("rst_mvalid", bus.m_valid, 0); chk("rst_cnt", bus.rq_ready, 2'b01);
    step();

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      drive_req(2'($urandom));
      bus.m_stall = ($urandom_range(0, 99) < 25);
      drive_rsp(35);
      step();
    end
    reset = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
